// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// hazard_detection_unit : ID-stage load-use stall and taken-branch flush.
// Optional macro HAZARD_PERF_EN adds stall/flush performance counters.
// Revision 1.0
// ============================================================================
module hazard_detection_unit #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  input  logic             MemRead_i,
  input  logic             BranchTaken_i,
  output logic             NoOp_o,
  output logic             Stall_o,
  output logic             PCWrite_o,
  output logic             Flush_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam logic [1:0] C_CNT_INIT = 2'(LU_STALL_CYCLES - 1);

  if ((LU_STALL_CYCLES < 1) || (LU_STALL_CYCLES > 3) || (CNT_W < 1)) begin : g_bad_params
    $error("hazard_detection_unit: illegal LU_STALL_CYCLES or CNT_W");
  end

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ex_memread_q;
  logic [4:0] ex_rd_q;
  logic       hazard;

  assign hazard = ex_memread_q && (ex_rd_q != 5'd0) &&
                  ((ex_rd_q == RS1addr_i) || (ex_rd_q == RS2addr_i));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    NoOp_o    = 1'b0;
    Stall_o   = 1'b0;
    PCWrite_o = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (hazard) begin
          NoOp_o    = 1'b1;
          Stall_o   = 1'b1;
          PCWrite_o = 1'b0;
          if (LU_STALL_CYCLES > 1) begin
            state_d = ST_STALL;
            cnt_d   = C_CNT_INIT;
          end
        end
      end
      ST_STALL: begin
        // Bubbles continue regardless of ID operands until the load reaches MEM/WB.
        NoOp_o    = 1'b1;
        Stall_o   = 1'b1;
        PCWrite_o = 1'b0;
        cnt_d     = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
    if (!rst_i) begin
      NoOp_o    = 1'b1;
      Stall_o   = 1'b0;
      PCWrite_o = 1'b0;
    end
  end

  assign Flush_o = rst_i && BranchTaken_i && !NoOp_o;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      ex_memread_q <= 1'b0;
      ex_rd_q      <= 5'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ex_memread_q <= NoOp_o ? 1'b0 : MemRead_i;
      ex_rd_q      <= NoOp_o ? 5'd0 : RDaddr_i;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Stall_o) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (Flush_o) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`endif

endmodule
`default_nettype wire
